// File: rtl/alu_ctrl_pkg.sv
// Shared opcode constants, sequencer state type and helpers for the ALU
// operation sequencer.
package alu_ctrl_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_LSR = 4'd5;
    localparam logic [3:0] OP_LSL = 4'd6;
    localparam logic [3:0] OP_MOD = 4'd7;
    localparam logic [3:0] OP_MUL = 4'd8;
    localparam logic [3:0] OP_DIV = 4'd9;
    localparam logic [3:0] OP_MAX = 4'd9;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        EXEC,
        DONE
    } seq_state_t;

    // Opcodes whose result is undefined when the divisor is zero.
    function automatic logic is_div_op(input logic [3:0] op);
        return (op == OP_MOD) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/btn_debounce_edge.sv
// Button conditioner: 2-flop synchronizer, debounce counter and a one-cycle
// pulse on each accepted press (falling edge of the active-low level).
module btn_debounce_edge #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);

    logic          sync_1;
    logic          sync_2;
    logic          level;
    logic [CW-1:0] cnt;
    logic          accept;

    // cnt counts consecutive samples that disagree with the accepted level;
    // the Nth such sample flips the level.
    assign accept = (sync_2 != level) && (cnt == CW'(DEBOUNCE_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_1 <= 1'b1;
            sync_2 <= 1'b1;
            level  <= 1'b1;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            sync_1 <= btn_n;
            sync_2 <= sync_1;
            press  <= accept && !sync_2;
            if (sync_2 == level) begin
                cnt <= '0;
            end else if (accept) begin
                level <= sync_2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Opcode selection from two debounced buttons and a LOAD/EXEC/DONE sequence
// that drives an external ALU and captures its result and flags.
module alu_op_sequencer
    import alu_ctrl_pkg::*;
#(
    parameter int N               = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int EXEC_CYCLES     = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         btn_inc_n,
    input  logic         btn_dec_n,
    input  logic         start,
    input  logic [N-1:0] sw_a,
    input  logic [N-1:0] sw_b,
    input  logic [N-1:0] alu_result,
    input  logic         alu_v,
    input  logic         alu_c,
    input  logic         alu_n,
    input  logic         alu_z,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic [3:0]   alu_control,
    output logic [3:0]   op_q,
    output logic [N-1:0] result_q,
    output logic [3:0]   flags_q,
    output logic         busy,
    output logic         done,
    output logic         err_div0
);

    localparam int EW = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;

    // Handshake: start is a one-cycle request honoured only in IDLE (ignored
    // while busy); done pulses once, in the cycle result_q/flags_q update.
    seq_state_t    state;
    seq_state_t    state_next;
    logic [EW-1:0] exec_cnt;
    logic          launch;
    logic          capture;
    logic          inc_press;
    logic          dec_press;
    logic          div0;

    btn_debounce_edge #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_inc (
        .clk   (clk),
        .rst_n (rst_n),
        .btn_n (btn_inc_n),
        .press (inc_press)
    );

    btn_debounce_edge #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_dec (
        .clk   (clk),
        .rst_n (rst_n),
        .btn_n (btn_dec_n),
        .press (dec_press)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        launch     = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = LOAD;
                    launch     = 1'b1;
                end
            end
            LOAD: state_next = EXEC;
            EXEC: begin
                if (exec_cnt == EW'(EXEC_CYCLES - 1)) begin
                    state_next = DONE;
                    capture    = 1'b1;
                end
            end
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            exec_cnt <= '0;
        end else if (state == LOAD) begin
            exec_cnt <= '0;
        end else if (state == EXEC) begin
            exec_cnt <= exec_cnt + EW'(1);
        end
    end

    assign div0 = is_div_op(alu_control) && (alu_b == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_a       <= '0;
            alu_b       <= '0;
            alu_control <= '0;
            result_q    <= '0;
            flags_q     <= '0;
            err_div0    <= 1'b0;
        end else if (launch) begin
            alu_a       <= sw_a;
            alu_b       <= sw_b;
            alu_control <= op_q;
            err_div0    <= 1'b0;
        end else if (capture) begin
            if (div0) begin
                result_q <= '0;
                flags_q  <= 4'b0001;
                err_div0 <= 1'b1;
            end else begin
                result_q <= alu_result;
                flags_q  <= {alu_v, alu_c, alu_n, alu_z};
            end
        end
    end

    // Presses outside IDLE are dropped; simultaneous inc and dec cancel.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q <= '0;
        end else if ((state == IDLE) && (inc_press ^ dec_press)) begin
            if (inc_press) begin
                op_q <= (op_q == OP_MAX) ? OP_ADD : op_q + 4'd1;
            end else begin
                op_q <= (op_q == OP_ADD) ? OP_MAX : op_q - 4'd1;
            end
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Clocked controller that sequences one multi-bit ALU (opcodes 0–9: add, sub, and, or, xor, lsr, lsl, mod, mul, div) for the board top level.
- Debounces two active-low push buttons to step the opcode up and down, with wrap-around.
- On a start pulse, latches the operands and drives the ALU. It then waits a programmable settle time and captures the result and the V/C/N/Z flags into registers. Capture completion is signalled with a done pulse.
- Traps mod and div by zero.

Parameters:
- N, 4, operand/result width.
- DEBOUNCE_CYCLES, 16, consecutive stable samples required before a button level is accepted (≥2).
- EXEC_CYCLES, 1, cycles the ALU inputs are held before capture (≥1).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  synchronous, active-low reset.
- btn_inc_n  input  1  raw button, active low; a press increments the opcode.
- btn_dec_n  input  1  raw button, active low; a press decrements the opcode.
- start  input  1  single-cycle request to execute the current opcode.
- sw_a  input  N  operand A source.
- sw_b  input  N  operand B source.
- alu_result  input  N  result from the ALU.
- alu_v, alu_c, alu_n, alu_z  input  1 each  flags from the ALU.
- alu_a  output  N  registered operand A to the ALU.
- alu_b  output  N  registered operand B to the ALU.
- alu_control  output  4  registered opcode to the ALU.
- op_q  output  4  currently selected opcode, for the 7-segment display.
- result_q  output  N  captured result.
- flags_q  output  4  captured flags, ordered {v,c,n,z}.
- busy  output  1  high whenever state ≠ IDLE.
- done  output  1  one-cycle pulse when result_q/flags_q update.
- err_div0  output  1  the last operation was mod or div with B = 0.

Behaviour:
- Clock and reset: one clock, clk. Reset is rst_n, synchronous and active-low; it is sampled only on the rising edge of clk.
- Reset values: op_q = 0, alu_a = 0, alu_b = 0, alu_control = 0, result_q = 0, flags_q = 0, busy = 0, done = 0, err_div0 = 0, state = IDLE.
- Reset mid-operation: aborts the operation and returns to IDLE with no done pulse. The button synchronizers and debounce counters also clear, to the released level.
- Button path, per button:
  - 2-flop synchronizer.
  - Debounce counter: the accepted level changes only after DEBOUNCE_CYCLES consecutive equal samples.
  - A 1→0 transition of the accepted level produces a single-cycle press pulse. Release produces nothing.
- Opcode update:
  - inc pulse: op_q+1, with 9→0.
  - dec pulse: op_q−1, with 0→9.
  - inc and dec pulses in the same cycle: no change.
  - Pulses arriving while busy = 1 are discarded, not queued.
  - op_q never leaves the range 0..9.
- FSM states are IDLE, LOAD, EXEC, DONE.
- IDLE:
  - start = 1 → LOAD, and on the same edge alu_a ← sw_a, alu_b ← sw_b, alu_control ← op_q, err_div0 ← 0.
  - start = 0 → stay in IDLE.
- LOAD → EXEC. The exec counter is cleared on this transition.
- EXEC:
  - Stay until EXEC_CYCLES cycles have elapsed, then → DONE.
  - On the exit edge, capture the result and flags, with the divide-by-zero override below.
- Divide-by-zero override at capture:
  - Condition: alu_control ∈ {7, 9} and alu_b = 0.
  - Then result_q ← 0, flags_q ← 4'b0001, err_div0 ← 1.
  - Otherwise result_q ← alu_result and flags_q ← {alu_v, alu_c, alu_n, alu_z}.
- DONE: done = 1 for exactly this cycle, then → IDLE.
- Latency: with start sampled at edge t, done is high during cycle t+2+EXEC_CYCLES, and result_q is valid from that cycle onward.
- start while busy is ignored.
- alu_a, alu_b and alu_control hold their values after the operation until the next start.
- result_q, flags_q and err_div0 hold until the next capture or reset.
- Flags pass through unmodified, including C and V for non-arithmetic opcodes. Interpreting them is the consumer's job.

Decomposition:
- Package alu_ctrl_pkg:
  - Opcode constants OP_ADD=0, OP_SUB=1, OP_AND=2, OP_OR=3, OP_XOR=4, OP_LSR=5, OP_LSL=6, OP_MOD=7, OP_MUL=8, OP_DIV=9.
  - OP_MAX = 9.
  - Enum typedef seq_state_t {IDLE, LOAD, EXEC, DONE}.
- Sub-module btn_debounce_edge: parameter DEBOUNCE_CYCLES; ports clk, rst_n, btn_n, press (synchronizer, debounce counter and falling-edge pulse). Instantiated twice.

Test Plan:
- Add: N=4, op 0, sw_a=5, sw_b=3, start → done at start+3 (EXEC_CYCLES=1); result_q=8, flags_q=4'b1010 (V=1, N=1); busy high for 3 cycles.
- Sub: op 1, a=3, b=5 → result_q=4'hE, N=1, Z=0. Then a=5, b=5 → result_q=0, Z=1.
- Divide by zero: op 9, b=0 → result_q=0, flags_q=4'b0001, err_div0=1. A following op 9 with a=8, b=2 → result_q=4, err_div0=0.
- Opcode wrap:
  - From reset, press dec once → op_q=9; press inc → op_q=0.
  - Inc and dec pulses in the same cycle → op_q unchanged.
  - A press during busy → op_q unchanged after done.
- Debounce: a low glitch of DEBOUNCE_CYCLES−1 cycles → no change. A low level held for DEBOUNCE_CYCLES+2 cycles → exactly one increment. Chatter on release → no change.
- Reset: assert rst_n=0 for one cycle while in EXEC → no done pulse; all outputs return to their reset values, including op_q=0. A start issued while busy during a normal run → ignored, exactly one done pulse.
